instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle control sequencer for the register-bank / ALU / data-RAM datapath.
- Fetches 16-bit instructions from a synchronous instruction memory.
- Decodes the 4-bit opcode and drives the datapath control strobes (write_enable_RB, read_ram, write_ram, alu_opcode, demultiplexor) one phase at a time.
- Adds a ready/ack handshake toward the data RAM, a program counter and halt/illegal reporting.

Parameters:
- PC_W, 8, program counter / instruction address width.
- PROG_LEN, 256, number of valid instruction slots; execution stops after slot PROG_LEN-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; sampled only in IDLE or HALT.
- imem_addr  output  PC_W  instruction memory address (= pc).
- imem_rd  output  1  instruction read strobe; data is valid on instr_data the following cycle.
- instr_data  input  16  instruction word: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt.
- ram_ack  input  1  data RAM completion for the current read_ram/write_ram access.
- rd_addr, rs_addr, rt_addr  output  4 each  register fields of the latched IR.
- write_enable_RB  output  1  register-bank write strobe.
- read_ram  output  1  data RAM read request.
- write_ram  output  1  data RAM write request.
- alu_opcode  output  4  ALU function select.
- demultiplexor  output  1  ALU result routing: 0 = register bank, 1 = data RAM.
- wb_from_ram  output  1  register-bank write-data mux: 1 = RAM read data.
- busy  output  1  high in every state except IDLE and HALT.
- done  output  1  high while in HALT.
- illegal  output  1  sticky: last halt was caused by an undefined opcode.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE, pc = 0, IR = 0, illegal = 0.
  - All outputs 0, including alu_opcode = 4'b0000. No output is ever x or z.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. All control strobes are registered state decodes and are 0 unless listed below.
- IDLE: on start -> FETCH with pc = 0.
- FETCH: imem_rd = 1, imem_addr = pc. Always -> DECODE.
- DECODE: IR <= instr_data; branch on instr_data[15:12]:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB -> EXEC.
  - 0100 SLT, 0101 NOR, 0110 SW, 0111 LW -> MEM.
  - 1111 HALT -> HALT.
  - Any other opcode -> HALT, illegal <= 1.
- EXEC (exactly 1 cycle):
  - write_enable_RB = 1, demultiplexor = 0.
  - alu_opcode: AND 0000, OR 0001, ADD 0010, SUB 0110.
  - Then ADVANCE.
- MEM:
  - SLT/NOR/SW: write_ram = 1, demultiplexor = 1.
  - alu_opcode: SLT 0111, NOR 1100, SW 0000 (ALU unused, driven 0).
  - LW: read_ram = 1, demultiplexor = 0, alu_opcode = 0000.
  - Strobes and IR are held stable until a cycle with ram_ack = 1; no timeout.
  - On ram_ack: LW -> WB; all others -> ADVANCE.
  - ram_ack in any other state is ignored.
- WB (1 cycle): write_enable_RB = 1, wb_from_ram = 1, then ADVANCE.
- ADVANCE (transition rule, not a state):
  - If pc == PROG_LEN-1 -> HALT; pc is not incremented.
  - Else pc <= pc+1, -> FETCH.
- HALT:
  - done = 1, busy = 0, pc holds.
  - On start -> FETCH, pc <= 0, illegal <= 0.
- start while busy: ignored.
- Latency: ALU op = 3 cycles (FETCH, DECODE, EXEC); SW/SLT/NOR = 3 + ack wait; LW = 4 + ack wait.
- rd_addr/rs_addr/rt_addr reflect the IR from the cycle after DECODE until the next DECODE.
- Reset mid-MEM drops write_ram/read_ram asynchronously; the RAM must tolerate an aborted request.

Test Plan:
- Reset: hold rst_n = 0 with start = 1 and ram_ack = 1 -> all outputs 0, busy = 0, imem_addr = 0; release -> remains IDLE until start.
- Program {0x2123 ADD, 0xF000 HALT}, pulse start:
  - cycle 1 imem_rd = 1, addr 0; cycle 3 write_enable_RB = 1, alu_opcode = 0010, rd/rs/rt = 1/2/3.
  - cycle 4 addr 1; cycle 5 DECODE; cycle 6 done = 1, pc = 1.
- Program {0x6045 SW} with ram_ack delayed 3 cycles -> write_ram = 1, demultiplexor = 1 held 4 cycles; pc stays 0 until the ack cycle; then FETCH addr 1.
- Program {0x7300 LW}, ack after 1 cycle -> read_ram = 1 for 2 cycles; next cycle write_enable_RB = 1 and wb_from_ram = 1 for exactly 1 cycle.
- Program {0xA000} -> done = 1, illegal = 1, no strobe ever high; start again with a valid program -> illegal clears on restart.
- PROG_LEN = 2, program {0x0123, 0x1123}:
  - halts after the second EXEC with pc = 1, no third fetch.
  - Separately, assert rst_n = 0 mid-MEM -> write_ram falls the same cycle and state is IDLE.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the register-bank / ALU / data-RAM
// control strobes, with a data-RAM ack handshake, program counter and halt/illegal status.
module instr_sequencer #(
  parameter int PC_W     = 8,
  parameter int PROG_LEN = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [15:0]     instr_data,
  input  logic            ram_ack,
  output logic [3:0]      rd_addr,
  output logic [3:0]      rs_addr,
  output logic [3:0]      rt_addr,
  output logic            write_enable_RB,
  output logic            read_ram,
  output logic            write_ram,
  output logic [3:0]      alu_opcode,
  output logic            demultiplexor,
  output logic            wb_from_ram,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);
  localparam logic [3:0]      OP_LW   = 4'b0111;
  localparam logic [3:0]      OP_HALT = 4'b1111;

  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic            r_illegal;

  logic [3:0] w_op, w_ir_op;
  logic       w_last, w_advance, w_restart, w_bad_op;
  state_t     w_adv_tgt;

  assign w_op      = instr_data[15:12];
  assign w_ir_op   = r_ir[15:12];
  assign w_last    = (r_pc == LAST_PC);
  assign w_adv_tgt = w_last ? S_HALT : S_FETCH;
  assign w_restart = ((r_state == S_IDLE) || (r_state == S_HALT)) && start;
  assign w_bad_op  = (w_op[3] == 1'b1) && (w_op != OP_HALT);
  // ADVANCE happens at the end of every completed instruction
  assign w_advance = (r_state == S_EXEC) || (r_state == S_WB) ||
                     ((r_state == S_MEM) && ram_ack && (w_ir_op != OP_LW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_restart) begin
        r_pc      <= '0;
        r_illegal <= 1'b0;
      end else if (w_advance && !w_last) begin
        r_pc <= r_pc + PC_W'(1);
      end
      if (r_state == S_DECODE) begin
        r_ir <= instr_data;
        if (w_bad_op) r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_op[3:2] == 2'b00)      w_next = S_EXEC;
        else if (w_op[3:2] == 2'b01) w_next = S_MEM;
        else                         w_next = S_HALT;
      end
      S_EXEC:   w_next = w_adv_tgt;
      S_MEM:    if (ram_ack) w_next = (w_ir_op == OP_LW) ? S_WB : w_adv_tgt;
      S_WB:     w_next = w_adv_tgt;
      S_HALT:   if (start) w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_rd         = 1'b0;
    write_enable_RB = 1'b0;
    read_ram        = 1'b0;
    write_ram       = 1'b0;
    alu_opcode      = 4'b0000;
    demultiplexor   = 1'b0;
    wb_from_ram     = 1'b0;
    done            = 1'b0;
    case (r_state)
      S_FETCH: imem_rd = 1'b1;
      S_EXEC: begin
        write_enable_RB = 1'b1;
        case (w_ir_op)
          4'b0001: alu_opcode = 4'b0001;
          4'b0010: alu_opcode = 4'b0010;
          4'b0011: alu_opcode = 4'b0110;
          default: alu_opcode = 4'b0000;
        endcase
      end
      S_MEM: begin
        // SLT/NOR/SW route the ALU result to RAM; LW only reads
        case (w_ir_op)
          4'b0100: begin write_ram = 1'b1; demultiplexor = 1'b1; alu_opcode = 4'b0111; end
          4'b0101: begin write_ram = 1'b1; demultiplexor = 1'b1; alu_opcode = 4'b1100; end
          4'b0110: begin write_ram = 1'b1; demultiplexor = 1'b1; end
          default: read_ram = 1'b1;
        endcase
      end
      S_WB: begin
        write_enable_RB = 1'b1;
        wb_from_ram     = 1'b1;
      end
      S_HALT:  done = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign illegal   = r_illegal;
  assign imem_addr = r_pc;
  assign rd_addr   = r_ir[11:8];
  assign rs_addr   = r_ir[7:4];
  assign rt_addr   = r_ir[3:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-opcode vector table plus hand sequences for
// ack stalls, LW writeback, illegal halt, end-of-program and reset mid-MEM.
module tb_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;

  // main DUT, PROG_LEN = 256
  logic rst_n, start, ram_ack;
  logic [7:0] imem_addr;
  logic imem_rd, wen, rr, wr, dmx, wbr, busy, done, illegal;
  logic [15:0] instr_data = 16'h0;
  logic [3:0] rd_a, rs_a, rt_a, alu;
  logic [15:0] mem [256];

  instr_sequencer #(.PC_W(8), .PROG_LEN(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .instr_data(instr_data), .ram_ack(ram_ack), .rd_addr(rd_a), .rs_addr(rs_a),
    .rt_addr(rt_a), .write_enable_RB(wen), .read_ram(rr), .write_ram(wr),
    .alu_opcode(alu), .demultiplexor(dmx), .wb_from_ram(wbr), .busy(busy),
    .done(done), .illegal(illegal));

  always @(posedge clk) if (imem_rd) instr_data <= mem[imem_addr];

  // short-program DUT, PROG_LEN = 2
  logic rst2_n, start2, ram_ack2;
  logic [7:0] imem_addr2;
  logic imem_rd2, wen2, rr2, wr2, dmx2, wbr2, busy2, done2, illegal2;
  logic [15:0] instr_data2 = 16'h0;
  logic [3:0] rd_a2, rs_a2, rt_a2, alu2;
  logic [15:0] mem2 [256];

  instr_sequencer #(.PC_W(8), .PROG_LEN(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2), .imem_addr(imem_addr2), .imem_rd(imem_rd2),
    .instr_data(instr_data2), .ram_ack(ram_ack2), .rd_addr(rd_a2), .rs_addr(rs_a2),
    .rt_addr(rt_a2), .write_enable_RB(wen2), .read_ram(rr2), .write_ram(wr2),
    .alu_opcode(alu2), .demultiplexor(dmx2), .wb_from_ram(wbr2), .busy(busy2),
    .done(done2), .illegal(illegal2));

  always @(posedge clk) if (imem_rd2) instr_data2 <= mem2[imem_addr2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // inputs are driven and outputs sampled at negedge; cycle k begins at posedge k
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic go();
    start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(output int dc);
    while (!done && cyc < 40) step();
    dc = cyc;
    chk("done_reached", {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] instr;
    logic        mem_path;
    logic [3:0]  alu;
    logic        wr, rd, dmx;
    int          done_cyc;
  } vec_t;

  vec_t vt [8];
  int dc, n_wr, n_rr, n_wb;
  logic any;

  initial begin
    vt[0] = '{16'h0123, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 6};
    vt[1] = '{16'h1123, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 6};
    vt[2] = '{16'h2123, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 6};
    vt[3] = '{16'h3123, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 6};
    vt[4] = '{16'h4123, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b1, 6};
    vt[5] = '{16'h5123, 1'b1, 4'b1100, 1'b1, 1'b0, 1'b1, 6};
    vt[6] = '{16'h6123, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 6};
    vt[7] = '{16'h7123, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 7};
    for (int i = 0; i < 256; i++) begin mem[i] = 16'hF000; mem2[i] = 16'hF000; end

    // reset with start/ack asserted
    rst_n = 1'b0; start = 1'b1; ram_ack = 1'b1;
    rst2_n = 1'b0; start2 = 1'b0; ram_ack2 = 1'b0;
    step(); step();
    chk("rst_addr", {24'd0, imem_addr}, 32'd0);
    chk("rst_outs", {7'd0, imem_rd, rd_a, rs_a, rt_a, wen, rr, wr, alu, dmx, wbr, busy, done, illegal}, 32'd0);
    start = 1'b0; ram_ack = 1'b0; rst_n = 1'b1; rst2_n = 1'b1;
    step(); step(); step();
    chk("idle_hold", {29'd0, busy, done, imem_rd}, 32'd0);

    // one-instruction programs followed by HALT, immediate ack
    foreach (vt[i]) begin
      mem[0] = vt[i].instr; mem[1] = 16'hF000; ram_ack = 1'b1;
      go();
      chk("fetch0", {23'd0, imem_rd, imem_addr}, {23'd0, 1'b1, 8'd0});
      step();
      chk("decode_busy", {31'd0, busy}, 32'd1);
      step();
      chk("c3_alu", {28'd0, alu}, {28'd0, vt[i].alu});
      chk("c3_strobes", {28'd0, wen, wr, rr, dmx},
          {28'd0, ~vt[i].mem_path, vt[i].wr, vt[i].rd, vt[i].dmx});
      chk("c3_regs", {20'd0, rd_a, rs_a, rt_a}, 32'h123);
      if (vt[i].rd) begin
        step();
        chk("lw_wb", {30'd0, wen, wbr}, 32'd3);
      end
      run_to_done(dc);
      chk("done_cycle", dc, vt[i].done_cyc);
      chk("halt_pc", {24'd0, imem_addr}, 32'd1);
      chk("no_illegal", {31'd0, illegal}, 32'd0);
    end

    // SW with ack sampled at the end of cycle 6: write_ram held cycles 3..6
    mem[0] = 16'h6045; ram_ack = 1'b0; n_wr = 0;
    go();
    while (cyc < 7) begin
      step();
      if (wr && dmx) n_wr++;
      if (cyc >= 3 && cyc <= 6) chk("sw_pc_hold", {24'd0, imem_addr}, 32'd0);
      if (cyc == 6) ram_ack = 1'b1;
      if (cyc == 7) ram_ack = 1'b0;
    end
    chk("sw_wr_cycles", n_wr, 4);
    chk("sw_fetch1", {23'd0, imem_rd, imem_addr}, {23'd0, 1'b1, 8'd1});
    run_to_done(dc);

    // LW with ack sampled at the end of cycle 4
    mem[0] = 16'h7300; n_rr = 0; n_wb = 0;
    go();
    while (cyc < 9) begin
      step();
      if (rr) n_rr++;
      if (wen && wbr) n_wb++;
      if (cyc == 4) ram_ack = 1'b1;
      if (cyc == 5) begin ram_ack = 1'b0; chk("lw_wb_c5", {30'd0, wen, wbr}, 32'd3); end
      if (cyc == 6) chk("lw_fetch_c6", {29'd0, wen, wbr, imem_rd}, 32'd1);
    end
    chk("lw_rd_cycles", n_rr, 2);
    chk("lw_wb_cycles", n_wb, 1);
    run_to_done(dc);

    // undefined opcode halts with illegal, no strobes
    mem[0] = 16'hA000; any = 1'b0;
    go();
    while (cyc < 6) begin
      any = any | wen | rr | wr | wbr | dmx;
      if (cyc == 3) chk("ill_halt", {30'd0, done, illegal}, 32'd3);
      step();
    end
    chk("ill_no_strobe", {31'd0, any}, 32'd0);
    chk("ill_sticky", {31'd0, illegal}, 32'd1);
    mem[0] = 16'h2123;
    go();
    chk("ill_cleared", {30'd0, illegal, imem_rd}, 32'd1);
    run_to_done(dc);
    chk("restart_done", dc, 6);

    // PROG_LEN = 2: halts after second EXEC, pc = 1, no third fetch
    mem2[0] = 16'h0123; mem2[1] = 16'h1123; n_rr = 0;
    start2 = 1'b1; cyc = 0; step(); start2 = 1'b0;
    while (cyc < 12) begin
      step();
      if (cyc == 6) chk("p2_exec2", {27'd0, wen2, alu2}, {27'd0, 1'b1, 4'b0001});
      if (cyc == 7) chk("p2_halt", {23'd0, done2, imem_addr2}, {23'd0, 1'b1, 8'd1});
      if (cyc >= 7 && imem_rd2) n_rr++;
    end
    chk("p2_no_fetch", n_rr, 0);

    // async reset in MEM drops write_ram before the next edge
    mem2[0] = 16'h6000; ram_ack2 = 1'b0;
    start2 = 1'b1; cyc = 0; step(); start2 = 1'b0;
    step(); step(); step();
    chk("mem_wr_before", {31'd0, wr2}, 32'd1);
    rst2_n = 1'b0;
    #1;
    chk("mem_rst_idle", {28'd0, wr2, busy2, done2, imem_rd2}, 32'd0);
    rst2_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
